// File: rtl/adder_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : adder_accum_pipe
//  Description : Registered add / subtract / accumulate / load unit with a
//                one-deep valid/ready output stage and optional saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_accum_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc_value
);

    localparam logic [1:0] c_MODE_ADD  = 2'b00;
    localparam logic [1:0] c_MODE_SUB  = 2'b01;
    localparam logic [1:0] c_MODE_ACC  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD = 2'b11;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_carry;
    logic             r_out_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_ext;
    logic             w_raw_carry;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    assign in_ready = !rst && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // B only participates in add/sub; masking it keeps an undriven B from
    // leaking X into the accumulate/load paths.
    assign w_b_eff = in_mode[1] ? '0 : in_b;

    always_comb begin
        w_ext = '0;
        case (in_mode)
            c_MODE_ADD:  w_ext = {1'b0, in_a} + {1'b0, w_b_eff};
            c_MODE_SUB:  w_ext = {1'b0, in_a} - {1'b0, w_b_eff};
            c_MODE_ACC:  w_ext = {1'b0, r_acc} + {1'b0, in_a};
            c_MODE_LOAD: w_ext = {1'b0, in_a};
            default:     w_ext = '0;
        endcase
    end

    assign w_raw_carry = (in_mode == c_MODE_LOAD) ? 1'b0 : w_ext[WIDTH];

    generate
        if (SAT_EN) begin : g_sat
            // Carry clamps high for add/acc; borrow clamps low for subtract.
            always_comb begin
                w_result = w_ext[WIDTH-1:0];
                w_ovf    = 1'b0;
                if (w_raw_carry) begin
                    w_ovf    = 1'b1;
                    w_result = (in_mode == c_MODE_SUB) ? '0 : '1;
                end
            end
        end else begin : g_wrap
            assign w_result = w_ext[WIDTH-1:0];
            assign w_ovf    = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_result;
                r_out_carry <= w_raw_carry;
                r_out_ovf   <= w_ovf;
                if (in_mode[1]) begin
                    r_acc <= w_result;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
    assign out_ovf   = r_out_ovf;
    assign acc_value = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_adder_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_accum_pipe
//  Description : Self-checking bench; runs wrap and saturating instances side
//                by side against a cycle-level arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_accum_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [1:0] in_mode = '0;
    logic       out_ready = 1'b0;

    logic       rdy0, ov0, c0, o0, rdy1, ov1, c1, o1;
    logic [7:0] sum0, acc0, sum1, acc1;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = wrapping, 1 = saturating.
    int m_valid [2];
    int m_sum   [2];
    int m_carry [2];
    int m_ovf   [2];
    int m_acc   [2];

    always #5 clk = ~clk;

    adder_accum_pipe #(.WIDTH(8), .SAT_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
        .out_carry(c0), .out_ovf(o0), .acc_value(acc0)
    );

    adder_accum_pipe #(.WIDTH(8), .SAT_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
        .out_carry(c1), .out_ovf(o1), .acc_value(acc1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input int sat, input int mode, input int a,
                                     input int b, input int acc,
                                     output int sum, output int cy, output int ovf);
        int t;
        cy  = 0;
        ovf = 0;
        case (mode)
            0:       begin t = a + b;   cy = (t > 255) ? 1 : 0; end
            1:       begin t = a - b;   cy = (t < 0)   ? 1 : 0; end
            2:       begin t = acc + a; cy = (t > 255) ? 1 : 0; end
            default: begin t = a; end
        endcase
        sum = t & 255;
        if (sat != 0 && cy != 0) begin
            ovf = 1;
            sum = (mode == 1) ? 0 : 255;
        end
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 0; m_sum[s] = 0; m_carry[s] = 0; m_ovf[s] = 0; m_acc[s] = 0;
        end
    endtask

    // One clock: drive, check ready, advance model at the edge, check outputs.
    task automatic cycle(input bit r, input bit iv, input int a, input int b,
                         input int mode, input bit ordy);
        int exp_rdy, acc_now, sum, cy, ovf;
        @(negedge clk);
        rst = r; in_valid = iv; in_a = a[7:0]; in_b = b[7:0];
        in_mode = mode[1:0]; out_ready = ordy;
        #1;
        exp_rdy = (!r && (m_valid[0] == 0 || ordy)) ? 1 : 0;
        chk("in_ready0", int'(rdy0), exp_rdy);
        chk("in_ready1", int'(rdy1), exp_rdy);
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (r) begin
                m_valid[s] = 0; m_sum[s] = 0; m_carry[s] = 0; m_ovf[s] = 0; m_acc[s] = 0;
            end else if (iv && exp_rdy != 0) begin
                acc_now = m_acc[s];
                ref_calc(s, mode, a, b, acc_now, sum, cy, ovf);
                m_valid[s] = 1; m_sum[s] = sum; m_carry[s] = cy; m_ovf[s] = ovf;
                if (mode >= 2) m_acc[s] = sum;
            end else if (ordy) begin
                m_valid[s] = 0;
            end
        end
        #1;
        chk("out_valid0", int'(ov0), m_valid[0]);
        chk("out_sum0",   int'(sum0), m_sum[0]);
        chk("out_carry0", int'(c0), m_carry[0]);
        chk("out_ovf0",   int'(o0), m_ovf[0]);
        chk("acc_value0", int'(acc0), m_acc[0]);
        chk("out_valid1", int'(ov1), m_valid[1]);
        chk("out_sum1",   int'(sum1), m_sum[1]);
        chk("out_carry1", int'(c1), m_carry[1]);
        chk("out_ovf1",   int'(o1), m_ovf[1]);
        chk("acc_value1", int'(acc1), m_acc[1]);
    endtask

    typedef struct {
        int mode; int a; int b;
        int s0; int c0; int acc0;
        int s1; int c1; int o1; int acc1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 'hF0, 'h20, 'h10, 1, 'h00, 'hFF, 1, 1, 'h00};
        vecs[1] = '{1, 'h05, 'h07, 'hFE, 1, 'h00, 'h00, 1, 1, 'h00};
        vecs[2] = '{1, 'h07, 'h05, 'h02, 0, 'h00, 'h02, 0, 0, 'h00};
        vecs[3] = '{3, 'h10, 'h99, 'h10, 0, 'h10, 'h10, 0, 0, 'h10};
        vecs[4] = '{2, 'h30, 'h55, 'h40, 0, 'h40, 'h40, 0, 0, 'h40};
        vecs[5] = '{2, 'hC5, 'h00, 'h05, 1, 'h05, 'hFF, 1, 1, 'hFF};

        model_reset();
        // Reset held two cycles with junk on the input bus.
        cycle(1, 1, 'hAA, 'h55, 0, 1);
        cycle(1, 1, 'hAA, 'h55, 0, 1);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_acc", int'(acc1), 0);

        // Directed vectors, back to back with the consumer always ready.
        foreach (vecs[i]) begin
            cycle(0, 1, vecs[i].a, vecs[i].b, vecs[i].mode, 1);
            chk("vec_sum0",  int'(sum0),  vecs[i].s0);
            chk("vec_cy0",   int'(c0),    vecs[i].c0);
            chk("vec_ovf0",  int'(o0),    0);
            chk("vec_acc0",  int'(acc0),  vecs[i].acc0);
            chk("vec_sum1",  int'(sum1),  vecs[i].s1);
            chk("vec_cy1",   int'(c1),    vecs[i].c1);
            chk("vec_ovf1",  int'(o1),    vecs[i].o1);
            chk("vec_acc1",  int'(acc1),  vecs[i].acc1);
        end
        cycle(0, 0, 0, 0, 0, 1);
        chk("drain_valid", int'(ov0), 0);

        // Backpressure: one result held for four cycles, then deliver + accept.
        cycle(0, 1, 'h11, 'h22, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 'h40 + k, 'h01, 2, 0);
            chk("bp_hold_sum", int'(sum0), 'h33);
            chk("bp_hold_acc", int'(acc0), 'h05);
        end
        cycle(0, 1, 'h03, 'h00, 2, 1);
        chk("bp_next_sum", int'(sum0), 'h08);
        chk("bp_next_valid", int'(ov0), 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Reset while a result is stalled: it must vanish with the accumulator.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 1, 'h22, 'h00, 2, 0);
        chk("mid_sum", int'(sum0), 'h22);
        cycle(1, 1, 'h01, 'h00, 2, 0);
        chk("mid_valid", int'(ov0), 0);
        chk("mid_acc", int'(acc0), 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("mid_no_deliver", int'(ov1), 0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
